// File: rtl/bird_physics.sv
// bird_physics: vertical-motion stage for the Flappy Bird bird.
//   Integrates gravity and flap impulses once per physics tick.
//   Runs the bird life cycle: waiting (IDLE), flying (FLYING), dead (DEAD).
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   tick            - one-cycle physics-step pulse
//   press           - synchronized flap button level
//   collision       - obstacle hit from the collision unit
//   birdTop/birdBot - registered vertical extent of the bird (9 bits)
//   birdLeft/Right  - constant horizontal extent (10 bits)
//   alive, dead     - state decodes (FLYING, DEAD)
module bird_physics #(
  parameter int SCREEN_H = 480,
  parameter int BIRD_H   = 16,
  parameter int BIRD_W   = 16,
  parameter int BIRD_X   = 100,
  parameter int START_Y  = 232,
  parameter int FLAP_VEL = -6,
  parameter int GRAVITY  = 1,
  parameter int MAX_FALL = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       press,
  input  logic       collision,
  output logic [8:0] birdTop,
  output logic [8:0] birdBot,
  output logic [9:0] birdLeft,
  output logic [9:0] birdRight,
  output logic       alive,
  output logic       dead
);

  typedef enum logic [1:0] {IDLE, FLYING, DEAD} state_t;

  state_t            state, state_n;
  logic signed [9:0] y, y_nx;
  logic signed [5:0] vel, vel_nx;
  logic              press_q, flap_pend, flap_pend_nx;
  logic [8:0]        bot_q;

  // 11-bit signed working values so y+vel and y+BIRD_H never wrap
  logic signed [10:0] vel_inc, vel_n, y_n;
  logic               flap_edge;

  assign flap_edge = press & ~press_q;

  always_comb begin
    state_n      = state;
    y_nx         = y;
    vel_nx       = vel;
    flap_pend_nx = flap_pend;
    vel_inc      = 11'(vel) + 11'(GRAVITY);
    vel_n        = '0;
    y_n          = '0;
    case (state)
      IDLE: begin
        if (flap_edge) begin
          state_n      = FLYING;
          flap_pend_nx = 1'b1;
        end
      end
      FLYING: begin
        if (collision) begin
          // collision wins over a same-cycle tick: freeze position
          state_n = DEAD;
        end else if (tick) begin
          if (flap_pend || flap_edge)     vel_n = 11'(FLAP_VEL);
          else if (vel_inc > 11'(MAX_FALL)) vel_n = 11'(MAX_FALL);
          else                            vel_n = vel_inc;
          y_n          = 11'(y) + vel_n;
          flap_pend_nx = 1'b0;
          if (y_n < 11'sd0) begin
            y_nx   = '0;
            vel_nx = '0;
          end else if (y_n + 11'(BIRD_H) > 11'(SCREEN_H)) begin
            y_nx    = 10'(SCREEN_H - BIRD_H);
            vel_nx  = vel_n[5:0];
            state_n = DEAD;
          end else begin
            y_nx   = y_n[9:0];
            vel_nx = vel_n[5:0];
          end
        end else if (flap_edge) begin
          flap_pend_nx = 1'b1;
        end
      end
      default: ; // DEAD: everything held until reset
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      y         <= 10'(START_Y);
      vel       <= '0;
      flap_pend <= 1'b0;
      press_q   <= 1'b0;
      bot_q     <= 9'(START_Y + BIRD_H - 1);
    end else begin
      state     <= state_n;
      y         <= y_nx;
      vel       <= vel_nx;
      flap_pend <= flap_pend_nx;
      press_q   <= press;
      bot_q     <= y_nx[8:0] + 9'(BIRD_H - 1);
    end
  end

  // 0 <= y <= SCREEN_H-BIRD_H always holds, so the low 9 bits are exact
  assign birdTop   = y[8:0];
  assign birdBot   = bot_q;
  assign birdLeft  = 10'(BIRD_X);
  assign birdRight = 10'(BIRD_X + BIRD_W - 1);
  assign alive     = (state == FLYING);
  assign dead      = (state == DEAD);

endmodule

// File: tb/tb_bird_physics.sv
// Self-checking bench for bird_physics: a reference model predicts the
// outputs for each driven cycle into a queue; they are popped and compared
// one cycle later. Directed checks add the absolute positions expected.
module tb_bird_physics;

  logic       clk = 1'b0;
  logic       reset, tick, press, collision;
  logic [8:0] birdTop, birdBot;
  logic [9:0] birdLeft, birdRight;
  logic       alive, dead;

  bird_physics dut (
    .clk(clk), .reset(reset), .tick(tick), .press(press),
    .collision(collision), .birdTop(birdTop), .birdBot(birdBot),
    .birdLeft(birdLeft), .birdRight(birdRight), .alive(alive), .dead(dead)
  );

  always #5 clk = ~clk;

  typedef struct {
    int top;
    int bot;
    int alv;
    int ded;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // reference model state (0 idle, 1 flying, 2 dead)
  int m_st, m_y, m_v, m_pq, m_fp;

  task automatic chk(input string tag, input int obs, input int expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model(input int r, input int t, input int p, input int c);
    int e, nv, ny;
    if (r != 0) begin
      m_st = 0; m_y = 232; m_v = 0; m_fp = 0; m_pq = 0;
      return;
    end
    e = (p != 0 && m_pq == 0) ? 1 : 0;
    if (m_st == 0) begin
      if (e != 0) begin m_st = 1; m_fp = 1; end
    end else if (m_st == 1) begin
      if (c != 0) m_st = 2;
      else if (t != 0) begin
        if (m_fp != 0 || e != 0) nv = -6;
        else nv = (m_v + 1 > 7) ? 7 : m_v + 1;
        m_fp = 0;
        ny = m_y + nv;
        if (ny < 0) begin m_y = 0; m_v = 0; end
        else if (ny + 16 > 480) begin m_y = 464; m_v = nv; m_st = 2; end
        else begin m_y = ny; m_v = nv; end
      end else if (e != 0) m_fp = 1;
    end
    m_pq = p;
  endtask

  // drive one cycle, predict, then compare at posedge+1
  task automatic step(input logic r, input logic t, input logic p, input logic c);
    exp_t ex;
    reset = r; tick = t; press = p; collision = c;
    model(r, t, p, c);
    ex.top = m_y; ex.bot = m_y + 15;
    ex.alv = (m_st == 1) ? 1 : 0; ex.ded = (m_st == 2) ? 1 : 0;
    exp_q.push_back(ex);
    @(posedge clk); #1;
    ex = exp_q.pop_front();
    chk("sb_top", int'(birdTop), ex.top);
    chk("sb_bot", int'(birdBot), ex.bot);
    chk("sb_alive", int'(alive), ex.alv);
    chk("sb_dead", int'(dead), ex.ded);
    if (alive && dead) chk("alive_dead_excl", 1, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; tick = 1'b0; press = 1'b0; collision = 1'b0;
    m_st = 0; m_y = 232; m_v = 0; m_pq = 0; m_fp = 0;

    // 1: reset state, ticks ignored in IDLE
    step(1, 0, 0, 0);
    chk("rst_top", int'(birdTop), 232);
    chk("rst_bot", int'(birdBot), 247);
    chk("left", int'(birdLeft), 100);
    chk("right", int'(birdRight), 115);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0);
      chk("idle_top", int'(birdTop), 232);
      chk("idle_alive", int'(alive), 0);
    end

    // 2: held press gives a single flap; ticks at 10/20/30
    for (int i = 0; i <= 30; i++) begin
      step(0, (i == 10 || i == 20 || i == 30), (i < 20), 0);
      if (i == 0)  chk("fly_alive", int'(alive), 1);
      if (i == 10) chk("t2_top1", int'(birdTop), 226);
      if (i == 20) chk("t2_top2", int'(birdTop), 221);
      if (i == 30) chk("t2_top3", int'(birdTop), 217);
    end

    // 3: free fall to the ground, then DEAD ignores everything
    n = 0;
    while (!dead && n < 200) begin
      step(0, 1, 0, 0);
      n++;
    end
    chk("fall_bound", (n < 200) ? 1 : 0, 1);
    chk("ground_top", int'(birdTop), 464);
    chk("ground_bot", int'(birdBot), 479);
    chk("ground_dead", int'(dead), 1);
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 1);
    chk("dead_hold_top", int'(birdTop), 464);
    chk("dead_hold_dead", int'(dead), 1);

    // 4: flap every tick clamps at the ceiling
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 39; i++) begin
      step(0, 1, 1, 0);
      step(0, 0, 0, 0);
    end
    chk("ceil_top", int'(birdTop), 0);
    chk("ceil_alive", int'(alive), 1);
    step(0, 1, 0, 0);
    chk("ceil_next", int'(birdTop), 1);

    // 5: reach y=200, then collision with tick in the same cycle
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 1, 0);
      step(0, 0, 0, 0);
    end
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    chk("pre_col_top", int'(birdTop), 200);
    step(0, 1, 0, 1);
    chk("col_dead", int'(dead), 1);
    chk("col_top", int'(birdTop), 200);

    // 6: reset mid-flight with a tick and an edge
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    step(1, 1, 1, 0);
    chk("mid_rst_top", int'(birdTop), 232);
    chk("mid_rst_alive", int'(alive), 0);
    chk("mid_rst_dead", int'(dead), 0);
    step(0, 1, 0, 0);
    chk("post_rst_top", int'(birdTop), 232);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
